// File: rtl/dl_coalesce_ctrl_if.sv
// dl_coalesce_ctrl_if: core request, memory row and per-core return signals of the load coalescer
interface dl_coalesce_ctrl_if #(
   parameter int N_CORES = 16,
   parameter int ADDR_W  = 16,
   parameter int WORD_W  = 16,
   parameter int WPR     = 4
);
   logic [N_CORES-1:0]        req;
   logic [N_CORES*ADDR_W-1:0] addr;
   logic                      mem_rd;
   logic [ADDR_W-1:0]         mem_row;
   logic [WPR*WORD_W-1:0]     mem_data;
   logic                      mem_valid;
   logic [N_CORES*WORD_W-1:0] dout;
   logic [N_CORES-1:0]        dvalid;
   logic                      busy;
   logic                      err;
   modport master (
      output req, addr, mem_data, mem_valid,
      input  mem_rd, mem_row, dout, dvalid, busy, err
   );
   modport slave (
      input  req, addr, mem_data, mem_valid,
      output mem_rd, mem_row, dout, dvalid, busy, err
   );
endinterface

// File: rtl/dl_coalesce_ctrl.sv
// dl_coalesce_ctrl: round-robin row-coalescing load controller between N cores and a wide-row memory
module dl_coalesce_ctrl #(
   parameter int N_CORES = 16,
   parameter int ADDR_W  = 16,
   parameter int WORD_W  = 16,
   parameter int WPR     = 4
) (
   input logic               clk,
   input logic               rst_n,
   dl_coalesce_ctrl_if.slave bus
);
   localparam int ROW_W = WPR * WORD_W;
   localparam int OFS_W = $clog2(WPR);
   localparam int RR_W  = $clog2(N_CORES);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t                   state;
   logic [N_CORES-1:0]       pending, grant, grant_nx;
   logic [ADDR_W-1:0]        addr_q [N_CORES];
   logic [RR_W-1:0]          rr, lead, lead_nx, idx;
   logic [ADDR_W-OFS_W-1:0]  lead_row;
   logic [WORD_W-1:0]        word [WPR];
   // leader search from rr with wrap, the matching-row grant mask, and the row split into words
   always_comb begin
      lead_nx = rr;
      idx = rr;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         idx = RR_W'((int'(rr) + k) % N_CORES);
         if (pending[idx]) lead_nx = idx;
      end
      lead_row = addr_q[lead_nx][ADDR_W-1:OFS_W];
      for (int i = 0; i < N_CORES; i++)
         grant_nx[i] = pending[i] && (addr_q[i][ADDR_W-1:OFS_W] == lead_row);
      for (int k = 0; k < WPR; k++)
         word[k] = bus.mem_data[ROW_W-1-k*WORD_W -: WORD_W];
   end
   // request capture, IDLE/ISSUE/WAIT sequencing and registered return of granted words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= '0;
         grant       <= '0;
         rr          <= '0;
         lead        <= '0;
         bus.mem_rd  <= 1'b0;
         bus.mem_row <= '0;
         bus.dout    <= '0;
         bus.dvalid  <= '0;
         bus.busy    <= 1'b0;
         bus.err     <= 1'b0;
         for (int i = 0; i < N_CORES; i++) addr_q[i] <= '0;
      end else begin
         bus.mem_rd <= 1'b0;
         bus.dvalid <= '0;
         for (int i = 0; i < N_CORES; i++)
            if (bus.req[i]) begin
               if (pending[i]) bus.err <= 1'b1;
               else begin
                  pending[i] <= 1'b1;
                  addr_q[i]  <= bus.addr[i*ADDR_W +: ADDR_W];
               end
            end
         case (state)
            IDLE: if (|pending) begin
               grant       <= grant_nx;
               lead        <= lead_nx;
               bus.mem_row <= ADDR_W'(lead_row);
               bus.mem_rd  <= 1'b1;
               bus.busy    <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (bus.mem_valid) begin
               for (int i = 0; i < N_CORES; i++)
                  if (grant[i]) begin
                     bus.dout[i*WORD_W +: WORD_W] <= word[addr_q[i][OFS_W-1:0]];
                     bus.dvalid[i] <= 1'b1;
                     pending[i]    <= 1'b0;
                  end
               rr       <= (lead == RR_W'(N_CORES - 1)) ? '0 : lead + 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
